// File: rtl/rv32i_rename_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_rename_regfile_if
// Description : Bundles the dispatch, writeback, retire and flush signals of
//               the rename stage / physical register file.
//               master : upstream side (dispatch, CDB, ROB) drives i_*.
//               slave  : rename stage drives o_*.
// Signals     : i_disp_vld/o_disp_rdy, i_src_ren, i_src_arch_idx,
//               i_dst_vld, i_dst_arch_idx, o_src_data_vld, o_src_data,
//               o_src_tag_vld, o_src_tag, o_dst_tag_vld, o_dst_tag,
//               o_dst_old_tag, i_wb_vld, i_wb_tag, i_wb_data, i_ret_vld,
//               i_ret_dst_vld, i_ret_arch_idx, i_ret_new_tag, i_ret_old_tag,
//               i_flush, o_free_cnt
// Revision    : 1.0 - initial release
// ============================================================================
interface rv32i_rename_regfile_if #(
  parameter int XLEN     = 32,
  parameter int NUM_ARCH = 32,
  parameter int NUM_PHYS = 64,
  parameter int NUM_SRC  = 2,
  parameter int AW       = $clog2(NUM_ARCH),
  parameter int PW       = $clog2(NUM_PHYS)
);
  // dispatch
  logic                    i_disp_vld;
  logic                    o_disp_rdy;
  logic [NUM_SRC-1:0]      i_src_ren;
  logic [NUM_SRC*AW-1:0]   i_src_arch_idx;
  logic                    i_dst_vld;
  logic [AW-1:0]           i_dst_arch_idx;
  logic [NUM_SRC-1:0]      o_src_data_vld;
  logic [NUM_SRC*XLEN-1:0] o_src_data;
  logic [NUM_SRC-1:0]      o_src_tag_vld;
  logic [NUM_SRC*PW-1:0]   o_src_tag;
  logic                    o_dst_tag_vld;
  logic [PW-1:0]           o_dst_tag;
  logic [PW-1:0]           o_dst_old_tag;
  // writeback
  logic                    i_wb_vld;
  logic [PW-1:0]           i_wb_tag;
  logic [XLEN-1:0]         i_wb_data;
  // retire / recovery
  logic                    i_ret_vld;
  logic                    i_ret_dst_vld;
  logic [AW-1:0]           i_ret_arch_idx;
  logic [PW-1:0]           i_ret_new_tag;
  logic [PW-1:0]           i_ret_old_tag;
  logic                    i_flush;
  logic [PW:0]             o_free_cnt;

  modport master (
    output i_disp_vld, i_src_ren, i_src_arch_idx, i_dst_vld, i_dst_arch_idx,
           i_wb_vld, i_wb_tag, i_wb_data, i_ret_vld, i_ret_dst_vld,
           i_ret_arch_idx, i_ret_new_tag, i_ret_old_tag, i_flush,
    input  o_disp_rdy, o_src_data_vld, o_src_data, o_src_tag_vld, o_src_tag,
           o_dst_tag_vld, o_dst_tag, o_dst_old_tag, o_free_cnt
  );

  modport slave (
    input  i_disp_vld, i_src_ren, i_src_arch_idx, i_dst_vld, i_dst_arch_idx,
           i_wb_vld, i_wb_tag, i_wb_data, i_ret_vld, i_ret_dst_vld,
           i_ret_arch_idx, i_ret_new_tag, i_ret_old_tag, i_flush,
    output o_disp_rdy, o_src_data_vld, o_src_data, o_src_tag_vld, o_src_tag,
           o_dst_tag_vld, o_dst_tag, o_dst_old_tag, o_free_cnt
  );
endinterface
`default_nettype wire

// File: rtl/rv32i_rename_regfile.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_rename_regfile
// Description : Rename stage plus physical register file. Holds a
//               speculative RAT, a committed RAT, a circular free list with
//               speculative/committed heads, and the physical RF with
//               per-entry valid bits. One dispatch (NUM_SRC lookups + one
//               allocation), one writeback and one retire per cycle; a flush
//               restores the committed state in a single cycle.
// Ports       : clk, rstn (async assert, active-low),
//               bus : rv32i_rename_regfile_if.slave (dispatch, writeback,
//                     retire, flush, free count)
// Options     : RV32I_RF_WB_BYPASS_EN - when defined, a source whose tag is
//               being written back in the fire cycle returns the writeback
//               data instead of a pending tag.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_rename_regfile #(
  parameter int XLEN     = 32,
  parameter int NUM_ARCH = 32,
  parameter int NUM_PHYS = 64,
  parameter int NUM_SRC  = 2,
  parameter int AW       = $clog2(NUM_ARCH),
  parameter int PW       = $clog2(NUM_PHYS),
  parameter int FL_DEPTH = NUM_PHYS - NUM_ARCH
) (
  input  wire logic              clk,
  input  wire logic              rstn,
  rv32i_rename_regfile_if.slave  bus
);

  localparam int               c_FLW     = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
  localparam logic [c_FLW-1:0] c_FL_LAST = c_FLW'(FL_DEPTH - 1);
  localparam logic [PW:0]      c_FL_FULL = (PW+1)'(FL_DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PW-1:0]     r_spec_rat   [NUM_ARCH];
  logic [PW-1:0]     r_commit_rat [NUM_ARCH];
  logic [PW-1:0]     r_fl         [FL_DEPTH];
  logic [XLEN-1:0]   r_rf         [NUM_PHYS];
  logic [NUM_PHYS-1:0] r_valid;
  logic [c_FLW-1:0]  r_spec_head;
  logic [c_FLW-1:0]  r_commit_head;
  logic [c_FLW-1:0]  r_tail;
  logic [PW:0]       r_free_cnt;

  logic [NUM_SRC-1:0]      r_src_data_vld;
  logic [NUM_SRC*XLEN-1:0] r_src_data;
  logic [NUM_SRC-1:0]      r_src_tag_vld;
  logic [NUM_SRC*PW-1:0]   r_src_tag;
  logic                    r_dst_tag_vld;
  logic [PW-1:0]           r_dst_tag;
  logic [PW-1:0]           r_dst_old_tag;

  // --------------------------------------------------------------------------
  // Handshake and pointer arithmetic
  // --------------------------------------------------------------------------
  function automatic logic [c_FLW-1:0] f_inc(input logic [c_FLW-1:0] p);
    f_inc = (p == c_FL_LAST) ? '0 : p + c_FLW'(1);
  endfunction

  logic             w_need_alloc;
  logic             w_disp_rdy;
  logic             w_fire;
  logic             w_pop;
  logic             w_push;
  logic [PW-1:0]    w_new_tag;
  logic [PW-1:0]    w_old_tag;
  logic [c_FLW-1:0] w_tail_nxt;
  logic [c_FLW-1:0] w_chead_nxt;
  logic [PW:0]      w_flush_cnt;

  assign w_need_alloc = bus.i_dst_vld & (bus.i_dst_arch_idx != '0);
  assign w_disp_rdy   = (r_free_cnt != '0) | ~w_need_alloc;
  assign w_fire       = bus.i_disp_vld & w_disp_rdy & ~bus.i_flush;
  assign w_pop        = w_fire & w_need_alloc;
  assign w_push       = bus.i_ret_vld & bus.i_ret_dst_vld & (bus.i_ret_arch_idx != '0);
  assign w_new_tag    = r_fl[r_spec_head];
  assign w_old_tag    = r_spec_rat[bus.i_dst_arch_idx];

  // Pointers as they will be after this cycle's retire, so a flush that
  // coincides with a retire restores the post-retire committed state.
  assign w_tail_nxt  = w_push ? f_inc(r_tail)        : r_tail;
  assign w_chead_nxt = w_push ? f_inc(r_commit_head) : r_commit_head;

  // Occupancy between the restored head and the tail. Equal pointers mean
  // a full list: the committed state always owns every non-mapped tag.
  always_comb begin
    w_flush_cnt = c_FL_FULL;
    if (w_tail_nxt > w_chead_nxt)
      w_flush_cnt = (PW+1)'(w_tail_nxt) - (PW+1)'(w_chead_nxt);
    else if (w_tail_nxt < w_chead_nxt)
      w_flush_cnt = c_FL_FULL - ((PW+1)'(w_chead_nxt) - (PW+1)'(w_tail_nxt));
  end

  // --------------------------------------------------------------------------
  // Source operand lookup (spec RAT before this instruction's own rename)
  // --------------------------------------------------------------------------
  wire logic [NUM_SRC-1:0]      w_src_dvld;
  wire logic [NUM_SRC*XLEN-1:0] w_src_data;
  wire logic [NUM_SRC-1:0]      w_src_tvld;
  wire logic [NUM_SRC*PW-1:0]   w_src_tag;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [AW-1:0]   w_idx;
    logic [PW-1:0]   w_map;
    logic            w_dv;
    logic [XLEN-1:0] w_dat;
    logic            w_tv;
    logic [PW-1:0]   w_tg;

    assign w_idx = bus.i_src_arch_idx[k*AW +: AW];
    assign w_map = r_spec_rat[w_idx];

    always_comb begin
      w_dv  = 1'b0;
      w_dat = '0;
      w_tv  = 1'b0;
      w_tg  = '0;
      if (bus.i_src_ren[k]) begin
        if (w_idx == '0) begin
          w_dv = 1'b1;
        end else if (r_valid[w_map]) begin
          w_dv  = 1'b1;
          w_dat = r_rf[w_map];
        end
`ifdef RV32I_RF_WB_BYPASS_EN
        else if (bus.i_wb_vld && (bus.i_wb_tag == w_map)) begin
          w_dv  = 1'b1;
          w_dat = bus.i_wb_data;
        end
`endif
        else begin
          w_tv = 1'b1;
          w_tg = w_map;
        end
      end
    end

    assign w_src_dvld[k]              = w_dv;
    assign w_src_data[k*XLEN +: XLEN] = w_dat;
    assign w_src_tvld[k]              = w_tv;
    assign w_src_tag[k*PW +: PW]      = w_tg;
  end

  // --------------------------------------------------------------------------
  // RAT, free list and register file
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        r_spec_rat[i]   <= PW'(i);
        r_commit_rat[i] <= PW'(i);
      end
      for (int i = 0; i < FL_DEPTH; i++)
        r_fl[i] <= PW'(NUM_ARCH + i);
      for (int i = 0; i < NUM_PHYS; i++)
        r_rf[i] <= '0;
      r_valid       <= '1;
      r_spec_head   <= '0;
      r_commit_head <= '0;
      r_tail        <= '0;
      r_free_cnt    <= c_FL_FULL;
    end else begin
      if (bus.i_wb_vld) begin
        r_rf[bus.i_wb_tag]    <= bus.i_wb_data;
        r_valid[bus.i_wb_tag] <= 1'b1;
      end

      if (w_push) begin
        r_commit_rat[bus.i_ret_arch_idx] <= bus.i_ret_new_tag;
        r_fl[r_tail]                     <= bus.i_ret_old_tag;
        r_tail                           <= w_tail_nxt;
        r_commit_head                    <= w_chead_nxt;
      end

      if (bus.i_flush) begin
        for (int i = 0; i < NUM_ARCH; i++)
          r_spec_rat[i] <= (w_push && (bus.i_ret_arch_idx == AW'(i))) ?
                           bus.i_ret_new_tag : r_commit_rat[i];
        r_spec_head <= w_chead_nxt;
        r_free_cnt  <= w_flush_cnt;
      end else begin
        if (w_pop) begin
          assert (!(bus.i_wb_vld && (bus.i_wb_tag == w_new_tag)));
          r_spec_rat[bus.i_dst_arch_idx] <= w_new_tag;
          r_valid[w_new_tag]             <= 1'b0;
          r_spec_head                    <= f_inc(r_spec_head);
        end
        if (w_push && !w_pop) begin
          assert (r_free_cnt < c_FL_FULL);
          r_free_cnt <= r_free_cnt + (PW+1)'(1);
        end else if (w_pop && !w_push) begin
          r_free_cnt <= r_free_cnt - (PW+1)'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered dispatch outputs: valid for one cycle after a fire
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_src_data_vld <= '0;
      r_src_data     <= '0;
      r_src_tag_vld  <= '0;
      r_src_tag      <= '0;
      r_dst_tag_vld  <= 1'b0;
      r_dst_tag      <= '0;
      r_dst_old_tag  <= '0;
    end else if (w_fire) begin
      r_src_data_vld <= w_src_dvld;
      r_src_data     <= w_src_data;
      r_src_tag_vld  <= w_src_tvld;
      r_src_tag      <= w_src_tag;
      r_dst_tag_vld  <= w_pop;
      r_dst_tag      <= w_pop ? w_new_tag : '0;
      r_dst_old_tag  <= w_pop ? w_old_tag : '0;
    end else begin
      r_src_data_vld <= '0;
      r_src_data     <= '0;
      r_src_tag_vld  <= '0;
      r_src_tag      <= '0;
      r_dst_tag_vld  <= 1'b0;
      r_dst_tag      <= '0;
      r_dst_old_tag  <= '0;
    end
  end

  assign bus.o_disp_rdy     = w_disp_rdy;
  assign bus.o_src_data_vld = r_src_data_vld;
  assign bus.o_src_data     = r_src_data;
  assign bus.o_src_tag_vld  = r_src_tag_vld;
  assign bus.o_src_tag      = r_src_tag;
  assign bus.o_dst_tag_vld  = r_dst_tag_vld;
  assign bus.o_dst_tag      = r_dst_tag;
  assign bus.o_dst_old_tag  = r_dst_old_tag;
  assign bus.o_free_cnt     = r_free_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_rename_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_rename_regfile
// Description : Self-checking bench for rv32i_rename_regfile. Directed
//               scenarios plus a randomized stream checked against a
//               queue-based model of the RATs, free list, ROB and RF.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_rename_regfile;
  localparam int XLEN = 32, NUM_ARCH = 32, NUM_PHYS = 64, NUM_SRC = 2;
  localparam int AW = 5, PW = 6, FL_DEPTH = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  rv32i_rename_regfile_if #(.XLEN(XLEN), .NUM_ARCH(NUM_ARCH), .NUM_PHYS(NUM_PHYS),
                            .NUM_SRC(NUM_SRC), .AW(AW), .PW(PW)) bus ();

  rv32i_rename_regfile #(.XLEN(XLEN), .NUM_ARCH(NUM_ARCH), .NUM_PHYS(NUM_PHYS),
                         .NUM_SRC(NUM_SRC), .AW(AW), .PW(PW), .FL_DEPTH(FL_DEPTH))
    dut (.clk(clk), .rstn(rstn), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  typedef struct { int arch; int nt; int ot; bit d; } rob_t;
  int          srat [NUM_ARCH];
  int          crat [NUM_ARCH];
  int          fq_spec [$];
  int          fq_com  [$];
  bit          vld [NUM_PHYS];
  logic [XLEN-1:0] rf [NUM_PHYS];
  rob_t        rob [$];

  logic                    e_rdy, a_rdy;
  logic [NUM_SRC-1:0]      e_sdv, e_stv;
  logic [NUM_SRC*XLEN-1:0] e_sdata;
  logic [NUM_SRC*PW-1:0]   e_stag;
  logic                    e_dtv;
  logic [PW-1:0]           e_dtag, e_dold;

  task automatic model_reset();
    for (int i = 0; i < NUM_ARCH; i++) begin srat[i] = i; crat[i] = i; end
    fq_spec.delete(); fq_com.delete();
    for (int i = NUM_ARCH; i < NUM_PHYS; i++) begin fq_spec.push_back(i); fq_com.push_back(i); end
    for (int p = 0; p < NUM_PHYS; p++) begin vld[p] = 1'b1; rf[p] = '0; end
    rob.delete();
  endtask

  task automatic idle();
    bus.i_disp_vld = 0; bus.i_src_ren = '0; bus.i_src_arch_idx = '0;
    bus.i_dst_vld = 0; bus.i_dst_arch_idx = '0;
    bus.i_wb_vld = 0; bus.i_wb_tag = '0; bus.i_wb_data = '0;
    bus.i_ret_vld = 0; bus.i_ret_dst_vld = 0; bus.i_ret_arch_idx = '0;
    bus.i_ret_new_tag = '0; bus.i_ret_old_tag = '0; bus.i_flush = 0;
  endtask

  task automatic retire_front();
    bus.i_ret_vld      = 1'b1;
    bus.i_ret_dst_vld  = rob[0].d;
    bus.i_ret_arch_idx = AW'(rob[0].arch);
    bus.i_ret_new_tag  = PW'(rob[0].nt);
    bus.i_ret_old_tag  = PW'(rob[0].ot);
  endtask

  // Predict outputs from the model, clock once, then advance the model.
  task automatic cycle();
    logic need, fire, pop, push, flush, wbv, dvld, rv, rdv;
    int dst, wt, ra, rn, ro, t, idx;
    logic [XLEN-1:0] wd;
    #1;
    dvld = bus.i_disp_vld; dst = int'(bus.i_dst_arch_idx);
    need = bus.i_dst_vld && (dst != 0); flush = bus.i_flush;
    wbv = bus.i_wb_vld; wt = int'(bus.i_wb_tag); wd = bus.i_wb_data;
    rv = bus.i_ret_vld; rdv = bus.i_ret_dst_vld; ra = int'(bus.i_ret_arch_idx);
    rn = int'(bus.i_ret_new_tag); ro = int'(bus.i_ret_old_tag);
    e_rdy = (fq_spec.size() != 0) || !need;
    a_rdy = bus.o_disp_rdy;
    fire = dvld && e_rdy && !flush;
    pop  = fire && need;
    push = rv && rdv && (ra != 0);
    e_sdv = '0; e_stv = '0; e_sdata = '0; e_stag = '0; e_dtv = 0; e_dtag = '0; e_dold = '0;
    if (fire) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (bus.i_src_ren[k]) begin
          idx = int'(bus.i_src_arch_idx[k*AW +: AW]);
          if (idx == 0) e_sdv[k] = 1'b1;
          else begin
            t = srat[idx];
            if (vld[t]) begin e_sdv[k] = 1'b1; e_sdata[k*XLEN +: XLEN] = rf[t]; end
`ifdef RV32I_RF_WB_BYPASS_EN
            else if (wbv && wt == t) begin e_sdv[k] = 1'b1; e_sdata[k*XLEN +: XLEN] = wd; end
`endif
            else begin e_stv[k] = 1'b1; e_stag[k*PW +: PW] = PW'(t); end
          end
        end
      end
    end
    if (pop) begin e_dtv = 1'b1; e_dtag = PW'(fq_spec[0]); e_dold = PW'(srat[dst]); end
    @(posedge clk); #1;
    if (wbv) begin rf[wt] = wd; vld[wt] = 1'b1; end
    if (rv && rob.size() > 0) void'(rob.pop_front());
    if (push) begin
      crat[ra] = rn;
      fq_spec.push_back(ro); fq_com.push_back(ro); void'(fq_com.pop_front());
    end
    if (pop) begin
      t = fq_spec.pop_front(); srat[dst] = t; vld[t] = 1'b0;
      rob.push_back('{dst, t, int'(e_dold), 1'b1});
    end else if (fire) rob.push_back('{dst, 0, 0, 1'b0});
    if (flush) begin srat = crat; fq_spec = fq_com; rob.delete(); end
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (bus.o_src_data_vld !== 2'b00) begin n_fail++; $display("FAIL reset_sdv: got %b want 00", bus.o_src_data_vld); end
    n_cmp++; if (bus.o_src_tag_vld !== 2'b00) begin n_fail++; $display("FAIL reset_stv: got %b want 00", bus.o_src_tag_vld); end
    n_cmp++; if (bus.o_dst_tag_vld !== 1'b0 || bus.o_dst_tag !== 6'd0) begin n_fail++; $display("FAIL reset_dst: got %b/%0d want 0/0", bus.o_dst_tag_vld, bus.o_dst_tag); end
    n_cmp++; if (bus.o_free_cnt !== 7'd32) begin n_fail++; $display("FAIL reset_free_cnt: got %0d want 32", bus.o_free_cnt); end
    n_cmp++; if (bus.o_disp_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b want 1", bus.o_disp_rdy); end
  endtask

  task automatic test_dispatch_basic();
    idle();
    bus.i_disp_vld = 1; bus.i_src_ren = 2'b11; bus.i_src_arch_idx = {5'd2, 5'd1};
    bus.i_dst_vld = 1; bus.i_dst_arch_idx = 5'd5;
    cycle(); idle();
    n_cmp++; if (bus.o_src_data_vld !== 2'b11 || bus.o_src_data !== 64'd0) begin n_fail++; $display("FAIL basic_src: got %b/%0h want 11/0", bus.o_src_data_vld, bus.o_src_data); end
    n_cmp++; if (bus.o_dst_tag_vld !== 1'b1 || bus.o_dst_tag !== 6'd32) begin n_fail++; $display("FAIL basic_dst_tag: got %b/%0d want 1/32", bus.o_dst_tag_vld, bus.o_dst_tag); end
    n_cmp++; if (bus.o_dst_old_tag !== 6'd5) begin n_fail++; $display("FAIL basic_old_tag: got %0d want 5", bus.o_dst_old_tag); end
    n_cmp++; if (bus.o_free_cnt !== 7'd31) begin n_fail++; $display("FAIL basic_free_cnt: got %0d want 31", bus.o_free_cnt); end
    cycle();
    n_cmp++; if (bus.o_dst_tag_vld !== 1'b0 || bus.o_src_data_vld !== 2'b00) begin n_fail++; $display("FAIL basic_clear: got %b/%b want 0/00", bus.o_dst_tag_vld, bus.o_src_data_vld); end
  endtask

  task automatic test_pending_wb();
    idle();
    bus.i_disp_vld = 1; bus.i_dst_vld = 1; bus.i_dst_arch_idx = 5'd5;
    cycle(); idle();
    n_cmp++; if (bus.o_dst_tag !== 6'd33 || bus.o_dst_old_tag !== 6'd32) begin n_fail++; $display("FAIL pend_realloc: got %0d/%0d want 33/32", bus.o_dst_tag, bus.o_dst_old_tag); end
    bus.i_disp_vld = 1; bus.i_src_ren = 2'b01; bus.i_src_arch_idx = {5'd0, 5'd5};
    cycle();
    n_cmp++; if (bus.o_src_tag_vld !== 2'b01 || bus.o_src_tag[5:0] !== 6'd33 || bus.o_src_data_vld !== 2'b00) begin n_fail++; $display("FAIL pend_tag: got %b/%0d want 01/33", bus.o_src_tag_vld, bus.o_src_tag[5:0]); end
    bus.i_wb_vld = 1; bus.i_wb_tag = 6'd33; bus.i_wb_data = 32'hDEAD;
    cycle();
`ifdef RV32I_RF_WB_BYPASS_EN
    n_cmp++; if (bus.o_src_data_vld !== 2'b01 || bus.o_src_data[31:0] !== 32'hDEAD) begin n_fail++; $display("FAIL bypass_data: got %b/%0h want 01/dead", bus.o_src_data_vld, bus.o_src_data[31:0]); end
`else
    n_cmp++; if (bus.o_src_tag_vld !== 2'b01 || bus.o_src_tag[5:0] !== 6'd33) begin n_fail++; $display("FAIL nobypass_tag: got %b/%0d want 01/33", bus.o_src_tag_vld, bus.o_src_tag[5:0]); end
`endif
    bus.i_wb_vld = 0;
    cycle(); idle();
    n_cmp++; if (bus.o_src_data_vld !== 2'b01 || bus.o_src_data[31:0] !== 32'hDEAD) begin n_fail++; $display("FAIL wb_reread: got %b/%0h want 01/dead", bus.o_src_data_vld, bus.o_src_data[31:0]); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < FL_DEPTH; i++) begin
      bus.i_disp_vld = 1; bus.i_dst_vld = 1; bus.i_dst_arch_idx = AW'(1 + i % 31);
      cycle();
    end
    idle();
    n_cmp++; if (bus.o_free_cnt !== 7'd0) begin n_fail++; $display("FAIL full_cnt: got %0d want 0", bus.o_free_cnt); end
    bus.i_disp_vld = 1; bus.i_dst_vld = 1; bus.i_dst_arch_idx = 5'd9;
    cycle();
    n_cmp++; if (a_rdy !== 1'b0) begin n_fail++; $display("FAIL full_rdy: got %b want 0", a_rdy); end
    n_cmp++; if (bus.o_dst_tag_vld !== 1'b0) begin n_fail++; $display("FAIL full_blocked: got %b want 0", bus.o_dst_tag_vld); end
    bus.i_dst_vld = 0; bus.i_src_ren = 2'b01; bus.i_src_arch_idx = '0;
    cycle();
    n_cmp++; if (a_rdy !== 1'b1 || bus.o_src_data_vld !== 2'b01) begin n_fail++; $display("FAIL full_nodst: got %b/%b want 1/01", a_rdy, bus.o_src_data_vld); end
    idle(); retire_front();
    cycle(); idle();
    n_cmp++; if (bus.o_free_cnt !== 7'd1) begin n_fail++; $display("FAIL full_retire_cnt: got %0d want 1", bus.o_free_cnt); end
    bus.i_disp_vld = 1; bus.i_dst_vld = 1; bus.i_dst_arch_idx = 5'd9;
    #1;
    n_cmp++; if (bus.o_disp_rdy !== 1'b1) begin n_fail++; $display("FAIL full_retire_rdy: got %b want 1", bus.o_disp_rdy); end
    cycle(); idle();
  endtask

  task automatic test_flush();
    do_reset();
    bus.i_disp_vld = 1; bus.i_dst_vld = 1; bus.i_dst_arch_idx = 5'd3; cycle();
    bus.i_dst_arch_idx = 5'd4; cycle();
    n_cmp++; if (bus.o_dst_tag !== 6'd33) begin n_fail++; $display("FAIL flush_alloc_x4: got %0d want 33", bus.o_dst_tag); end
    idle(); retire_front(); cycle();
    idle(); bus.i_flush = 1; bus.i_disp_vld = 1; bus.i_dst_vld = 1; bus.i_dst_arch_idx = 5'd8;
    cycle(); idle();
    n_cmp++; if (bus.o_free_cnt !== 7'd32) begin n_fail++; $display("FAIL flush_cnt: got %0d want 32", bus.o_free_cnt); end
    n_cmp++; if (bus.o_dst_tag_vld !== 1'b0) begin n_fail++; $display("FAIL flush_ignored: got %b want 0", bus.o_dst_tag_vld); end
    bus.i_disp_vld = 1; bus.i_src_ren = 2'b11; bus.i_src_arch_idx = {5'd4, 5'd3};
    bus.i_dst_vld = 1; bus.i_dst_arch_idx = 5'd6;
    cycle(); idle();
    n_cmp++; if (bus.o_src_tag_vld !== 2'b01 || bus.o_src_tag[5:0] !== 6'd32) begin n_fail++; $display("FAIL flush_rat_x3: got %b/%0d want 01/32", bus.o_src_tag_vld, bus.o_src_tag[5:0]); end
    n_cmp++; if (bus.o_src_data_vld !== 2'b10) begin n_fail++; $display("FAIL flush_rat_x4: got %b want 10", bus.o_src_data_vld); end
    n_cmp++; if (bus.o_dst_tag !== 6'd33 || bus.o_dst_old_tag !== 6'd6) begin n_fail++; $display("FAIL flush_next_alloc: got %0d/%0d want 33/6", bus.o_dst_tag, bus.o_dst_old_tag); end
  endtask

  task automatic test_random(int n);
    int j;
    for (int c = 0; c < n; c++) begin
      idle();
      bus.i_disp_vld     = ($urandom_range(0, 3) != 0);
      bus.i_src_ren      = NUM_SRC'($urandom);
      bus.i_src_arch_idx = (NUM_SRC*AW)'($urandom);
      bus.i_dst_vld      = 1'($urandom);
      bus.i_dst_arch_idx = AW'($urandom);
      bus.i_flush        = ($urandom_range(0, 31) == 0);
      if (rob.size() > 0 && $urandom_range(0, 1) == 1) begin
        j = $urandom_range(0, rob.size() - 1);
        if (rob[j].d && !(fq_spec.size() > 0 && fq_spec[0] == rob[j].nt)) begin
          bus.i_wb_vld = 1; bus.i_wb_tag = PW'(rob[j].nt); bus.i_wb_data = $urandom;
        end
      end
      if (rob.size() > 0 && $urandom_range(0, 1) == 1) retire_front();
      cycle();
      n_cmp++; if (a_rdy !== e_rdy) begin n_fail++; $display("FAIL rnd_rdy c=%0d: got %b want %b", c, a_rdy, e_rdy); end
      n_cmp++; if (bus.o_src_data_vld !== e_sdv) begin n_fail++; $display("FAIL rnd_sdv c=%0d: got %b want %b", c, bus.o_src_data_vld, e_sdv); end
      n_cmp++; if (bus.o_src_data !== e_sdata) begin n_fail++; $display("FAIL rnd_sdata c=%0d: got %0h want %0h", c, bus.o_src_data, e_sdata); end
      n_cmp++; if (bus.o_src_tag_vld !== e_stv) begin n_fail++; $display("FAIL rnd_stv c=%0d: got %b want %b", c, bus.o_src_tag_vld, e_stv); end
      n_cmp++; if (bus.o_src_tag !== e_stag) begin n_fail++; $display("FAIL rnd_stag c=%0d: got %0h want %0h", c, bus.o_src_tag, e_stag); end
      n_cmp++; if (bus.o_dst_tag_vld !== e_dtv) begin n_fail++; $display("FAIL rnd_dtv c=%0d: got %b want %b", c, bus.o_dst_tag_vld, e_dtv); end
      n_cmp++; if (bus.o_dst_tag !== e_dtag) begin n_fail++; $display("FAIL rnd_dtag c=%0d: got %0d want %0d", c, bus.o_dst_tag, e_dtag); end
      n_cmp++; if (bus.o_dst_old_tag !== e_dold) begin n_fail++; $display("FAIL rnd_dold c=%0d: got %0d want %0d", c, bus.o_dst_old_tag, e_dold); end
      n_cmp++; if (int'(bus.o_free_cnt) !== fq_spec.size()) begin n_fail++; $display("FAIL rnd_free_cnt c=%0d: got %0d want %0d", c, bus.o_free_cnt, fq_spec.size()); end
    end
    idle();
  endtask

  task automatic test_async_reset();
    idle();
    bus.i_disp_vld = 1; bus.i_src_ren = 2'b01; bus.i_src_arch_idx = '0;
    cycle(); idle();
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (bus.o_src_data_vld !== 2'b00 || bus.o_dst_tag_vld !== 1'b0) begin n_fail++; $display("FAIL arst_vld: got %b/%b want 00/0", bus.o_src_data_vld, bus.o_dst_tag_vld); end
    n_cmp++; if (bus.o_free_cnt !== 7'd32) begin n_fail++; $display("FAIL arst_cnt: got %0d want 32", bus.o_free_cnt); end
    @(negedge clk); rstn = 1'b1;
    model_reset();
    @(posedge clk); #1;
    bus.i_disp_vld = 1; bus.i_src_ren = 2'b11; bus.i_src_arch_idx = {5'd0, 5'd7};
    bus.i_dst_vld = 1; bus.i_dst_arch_idx = 5'd7;
    cycle(); idle();
    n_cmp++; if (bus.o_dst_tag !== 6'd32 || bus.o_dst_old_tag !== 6'd7) begin n_fail++; $display("FAIL arst_identity: got %0d/%0d want 32/7", bus.o_dst_tag, bus.o_dst_old_tag); end
    n_cmp++; if (bus.o_src_data_vld !== 2'b11 || bus.o_free_cnt !== 7'd31) begin n_fail++; $display("FAIL arst_after: got %b/%0d want 11/31", bus.o_src_data_vld, bus.o_free_cnt); end
  endtask

  initial begin
    idle();
    test_reset();
    test_dispatch_basic();
    test_pending_wb();
    test_full();
    test_flush();
    test_random(2000);
    test_async_reset();
    test_random(500);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
